// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register scoreboard for the in-order pipeline.
// Each architectural register (x0 excluded) records whether a result is still
// in flight, how many cycles remain until it reaches the bypass network (cnt),
// and which bypass stage holds it once it has arrived (age). Decode is stalled
// on RAW and WAW hazards, bypass selects are produced per source, and a
// one-deep shadow allows the instruction issued last cycle to be rolled back on flush.
//
// Decode handshake: dec_valid offers the decode instruction; issue is the accept
// and is asserted only when dec_valid is high and neither stall, hold nor flush
// blocks it. The instruction is consumed on the rising edge where issue is high;
// with issue low, decode must present the same instruction again next cycle.
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int MAX_LAT  = 8,
  parameter int LAT_W    = 4,
  parameter int NUM_FWD  = 3,
  parameter int STG_W    = $clog2(NUM_FWD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [REG_W-1:0] dec_src1,
  input  logic [REG_W-1:0] dec_src2,
  input  logic             dec_use_src1,
  input  logic             dec_use_src2,
  input  logic [REG_W-1:0] dec_dst,
  input  logic             dec_reg_write,
  input  logic [LAT_W-1:0] dec_lat,
  input  logic             hold,
  input  logic             flush,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_dst,
  output logic             issue,
  output logic             stall,
  output logic             byp_src1,
  output logic             byp_src2,
  output logic [STG_W-1:0] byp_stage1,
  output logic [STG_W-1:0] byp_stage2,
  output logic [31:0]      perf_stall_cycles
);

  localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LAT);
  localparam logic [STG_W-1:0] AGE_MAX = STG_W'(NUM_FWD - 1);

  // Per-register scoreboard state
  logic             busy_q [NUM_REGS];
  logic             busy_d [NUM_REGS];
  logic [LAT_W-1:0] cnt_q  [NUM_REGS];
  logic [LAT_W-1:0] cnt_d  [NUM_REGS];
  logic [STG_W-1:0] age_q  [NUM_REGS];
  logic [STG_W-1:0] age_d  [NUM_REGS];

  // One-deep rollback shadow: prior entry of the register written by the last issue
  logic             sh_valid_q, sh_valid_d;
  logic [REG_W-1:0] sh_idx_q,   sh_idx_d;
  logic             sh_busy_q,  sh_busy_d;
  logic [LAT_W-1:0] sh_cnt_q,   sh_cnt_d;
  logic [STG_W-1:0] sh_age_q,   sh_age_d;

  logic [31:0]      perf_q, perf_d;

  logic [LAT_W-1:0] lat_eff;
  logic             raw1, raw2, waw, alloc;

  // Hazard detection, issue decision and bypass selection for the decode instruction
  always_comb begin
    // A zero latency is illegal; it behaves as a single-cycle producer.
    lat_eff    = (dec_lat == '0) ? LAT_ONE : dec_lat;
    raw1       = dec_valid & dec_use_src1 & busy_q[dec_src1] & (cnt_q[dec_src1] != '0);
    raw2       = dec_valid & dec_use_src2 & busy_q[dec_src2] & (cnt_q[dec_src2] != '0);
    // An older producer finishing at or after the new one would overwrite it.
    waw        = dec_valid & dec_reg_write & (dec_dst != '0) & busy_q[dec_dst] &
                 (cnt_q[dec_dst] >= lat_eff);
    stall      = raw1 | raw2 | waw;
    issue      = dec_valid & ~stall & ~hold & ~flush;
    alloc      = issue & dec_reg_write & (dec_dst != '0);
    byp_src1   = dec_use_src1 & busy_q[dec_src1] & (cnt_q[dec_src1] == '0);
    byp_src2   = dec_use_src2 & busy_q[dec_src2] & (cnt_q[dec_src2] == '0);
    byp_stage1 = byp_src1 ? age_q[dec_src1] : '0;
    byp_stage2 = byp_src2 ? age_q[dec_src2] : '0;
  end

  // Next-state of each entry: rollback or countdown, then allocation, then writeback clear
  always_comb begin
    busy_d[0] = 1'b0;
    cnt_d[0]  = '0;
    age_d[0]  = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      busy_d[r] = busy_q[r];
      cnt_d[r]  = cnt_q[r];
      age_d[r]  = age_q[r];
      if (flush && sh_valid_q && (sh_idx_q == REG_W'(r))) begin
        // Restored entry skips this cycle's countdown.
        busy_d[r] = sh_busy_q;
        cnt_d[r]  = sh_cnt_q;
        age_d[r]  = sh_age_q;
      end else if (!hold && busy_q[r]) begin
        if (cnt_q[r] != '0) begin
          cnt_d[r] = cnt_q[r] - LAT_ONE;
        end else if (age_q[r] != AGE_MAX) begin
          age_d[r] = age_q[r] + STG_W'(1);
        end
      end
      // A new producer for this register takes precedence over a retiring writeback.
      if (alloc && (dec_dst == REG_W'(r))) begin
        busy_d[r] = 1'b1;
        cnt_d[r]  = lat_eff - LAT_ONE;
        age_d[r]  = '0;
      end else if (wb_valid && (wb_dst == REG_W'(r))) begin
        busy_d[r] = 1'b0;
        cnt_d[r]  = '0;
        age_d[r]  = '0;
      end
    end
  end

  // Shadow capture on allocation and stall-cycle counting
  always_comb begin
    sh_valid_d = alloc;
    sh_idx_d   = sh_idx_q;
    sh_busy_d  = sh_busy_q;
    sh_cnt_d   = sh_cnt_q;
    sh_age_d   = sh_age_q;
    if (alloc) begin
      sh_idx_d  = dec_dst;
      sh_busy_d = busy_q[dec_dst];
      sh_cnt_d  = cnt_q[dec_dst];
      sh_age_d  = age_q[dec_dst];
    end
    perf_d = perf_q;
    if (stall && !hold && !flush) begin
      perf_d = perf_q + 32'd1;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        busy_q[r] <= 1'b0;
        cnt_q[r]  <= '0;
        age_q[r]  <= '0;
      end
      sh_valid_q <= 1'b0;
      sh_idx_q   <= '0;
      sh_busy_q  <= 1'b0;
      sh_cnt_q   <= '0;
      sh_age_q   <= '0;
      perf_q     <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        busy_q[r] <= busy_d[r];
        cnt_q[r]  <= cnt_d[r];
        age_q[r]  <= age_d[r];
      end
      sh_valid_q <= sh_valid_d;
      sh_idx_q   <= sh_idx_d;
      sh_busy_q  <= sh_busy_d;
      sh_cnt_q   <= sh_cnt_d;
      sh_age_q   <= sh_age_d;
      perf_q     <= perf_d;
    end
  end

  assign perf_stall_cycles = perf_q;

  // A valid decode must carry a latency in 1..MAX_LAT.
  lat_legal: assert property (@(posedge clk) disable iff (rst)
    dec_valid |-> ((dec_lat != '0) && (dec_lat <= LAT_MAX)));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios for hazard_scoreboard, checked every
// cycle against a virtual-time model plus hand-computed literal expectations.
module tb_hazard_scoreboard;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst;
  logic        dec_valid;
  logic [4:0]  dec_src1, dec_src2, dec_dst, wb_dst;
  logic        dec_use_src1, dec_use_src2, dec_reg_write;
  logic [3:0]  dec_lat;
  logic        hold, flush, wb_valid;
  logic        issue, stall, byp_src1, byp_src2;
  logic [1:0]  byp_stage1, byp_stage2;
  logic [31:0] perf_stall_cycles;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk               (clk),
    .rst               (rst),
    .dec_valid         (dec_valid),
    .dec_src1          (dec_src1),
    .dec_src2          (dec_src2),
    .dec_use_src1      (dec_use_src1),
    .dec_use_src2      (dec_use_src2),
    .dec_dst           (dec_dst),
    .dec_reg_write     (dec_reg_write),
    .dec_lat           (dec_lat),
    .hold              (hold),
    .flush             (flush),
    .wb_valid          (wb_valid),
    .wb_dst            (wb_dst),
    .issue             (issue),
    .stall             (stall),
    .byp_src1          (byp_src1),
    .byp_src2          (byp_src2),
    .byp_stage1        (byp_stage1),
    .byp_stage2        (byp_stage2),
    .perf_stall_cycles (perf_stall_cycles)
  );

  // ---------------- literal expectations for the current cycle ----------------
  bit          lit_on;
  bit          lit_perf_on;
  string       lit_name;
  logic        lit_stall, lit_issue, lit_byp;
  logic [1:0]  lit_stg;
  logic [31:0] lit_perf;

  // ---------------- counters ----------------
  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- behavioural model ----------------
  // Virtual time vt advances on every unheld edge. A producer issued at vt=v
  // with latency L becomes bypassable once vt reaches v+L; its stage is the
  // number of unheld cycles since then, capped at the last bypass stage.
  int          vt;
  bit          m_busy  [32];
  int          m_ready [32];
  bit          sh_v;
  logic [4:0]  sh_i;
  bit          sh_b;
  int          sh_r;
  int          sh_t;
  logic [31:0] m_perf;
  bit          e_stall, e_issue, e_b1, e_b2;
  logic [1:0]  e_g1, e_g2;

  function automatic int lat_of(input logic [3:0] l);
    return (l == 4'd0) ? 1 : int'(l);
  endfunction

  function automatic bit pending(input logic [4:0] r);
    return (r != 5'd0) && m_busy[r] && (m_ready[r] > vt);
  endfunction

  function automatic bit arrived(input logic [4:0] r);
    return (r != 5'd0) && m_busy[r] && (m_ready[r] <= vt);
  endfunction

  function automatic logic [1:0] stage_of(input logic [4:0] r);
    int a;
    a = vt - m_ready[r];
    return (a > 2) ? 2'd2 : 2'(a);
  endfunction

  task automatic model_clear();
    vt = 0;
    for (int r = 0; r < 32; r++) begin
      m_busy[r]  = 1'b0;
      m_ready[r] = 0;
    end
    sh_v   = 1'b0;
    sh_i   = 5'd0;
    sh_b   = 1'b0;
    sh_r   = 0;
    sh_t   = 0;
    m_perf = 32'd0;
  endtask

  task automatic model_calc();
    bit waw;
    waw = dec_reg_write && (dec_dst != 5'd0) && m_busy[dec_dst] &&
          ((m_ready[dec_dst] - vt) >= lat_of(dec_lat));
    e_stall = dec_valid && ((dec_use_src1 && pending(dec_src1)) ||
                            (dec_use_src2 && pending(dec_src2)) || waw);
    e_issue = dec_valid && !e_stall && !hold && !flush;
    e_b1    = dec_use_src1 && arrived(dec_src1);
    e_b2    = dec_use_src2 && arrived(dec_src2);
    e_g1    = e_b1 ? stage_of(dec_src1) : 2'd0;
    e_g2    = e_b2 ? stage_of(dec_src2) : 2'd0;
  endtask

  task automatic model_step();
    bit alloc;
    int vn;
    model_calc();
    alloc = e_issue && dec_reg_write && (dec_dst != 5'd0);
    vn    = hold ? vt : vt + 1;
    if (e_stall && !hold && !flush) m_perf = m_perf + 32'd1;
    if (flush && sh_v) begin
      m_busy[sh_i]  = sh_b;
      m_ready[sh_i] = sh_r + (vn - sh_t);
    end
    if (alloc) begin
      sh_v             = 1'b1;
      sh_i             = dec_dst;
      sh_b             = m_busy[dec_dst];
      sh_r             = m_ready[dec_dst];
      sh_t             = vt;
      m_busy[dec_dst]  = 1'b1;
      m_ready[dec_dst] = vt + lat_of(dec_lat);
    end else begin
      sh_v = 1'b0;
    end
    if (wb_valid && (wb_dst != 5'd0) && !(alloc && (dec_dst == wb_dst)))
      m_busy[wb_dst] = 1'b0;
    vt = vn;
  endtask

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin : compare_proc
    model_clear();
    forever begin
      @(negedge clk);
      if (rst) model_clear();
      model_calc();
      chk("model_stall",  32'(stall),      32'(e_stall));
      chk("model_issue",  32'(issue),      32'(e_issue));
      chk("model_byp1",   32'(byp_src1),   32'(e_b1));
      chk("model_stage1", 32'(byp_stage1), 32'(e_g1));
      chk("model_byp2",   32'(byp_src2),   32'(e_b2));
      chk("model_stage2", 32'(byp_stage2), 32'(e_g2));
      chk("model_perf",   perf_stall_cycles, m_perf);
      if (lit_on) begin
        chk({lit_name, "_stall"}, 32'(stall),      32'(lit_stall));
        chk({lit_name, "_issue"}, 32'(issue),      32'(lit_issue));
        chk({lit_name, "_byp1"},  32'(byp_src1),   32'(lit_byp));
        chk({lit_name, "_stg1"},  32'(byp_stage1), 32'(lit_stg));
      end
      if (lit_perf_on) chk({lit_name, "_perf"}, perf_stall_cycles, lit_perf);
      @(posedge clk);
      if (rst) model_clear();
      else     model_step();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    dec_valid     = 1'b0;
    dec_src1      = 5'd0;
    dec_src2      = 5'd0;
    dec_use_src1  = 1'b0;
    dec_use_src2  = 1'b0;
    dec_dst       = 5'd0;
    dec_reg_write = 1'b0;
    dec_lat       = 4'd1;
    hold          = 1'b0;
    flush         = 1'b0;
    wb_valid      = 1'b0;
    wb_dst        = 5'd0;
  endtask

  task automatic drive_dec(input logic [4:0] s1, input logic u1, input logic [4:0] s2,
                           input logic u2, input logic [4:0] d, input logic w,
                           input logic [3:0] l);
    dec_valid     = 1'b1;
    dec_src1      = s1;
    dec_use_src1  = u1;
    dec_src2      = s2;
    dec_use_src2  = u2;
    dec_dst       = d;
    dec_reg_write = w;
    dec_lat       = l;
  endtask

  task automatic expect_lit(input string name, input logic s, input logic i,
                            input logic b, input logic [1:0] g);
    lit_on    = 1'b1;
    lit_name  = name;
    lit_stall = s;
    lit_issue = i;
    lit_byp   = b;
    lit_stg   = g;
  endtask

  task automatic expect_perf(input logic [31:0] p);
    lit_perf_on = 1'b1;
    lit_perf    = p;
  endtask

  // Advance one cycle; per-cycle controls and literal expectations drop back to idle.
  task automatic step();
    @(posedge clk);
    #1;
    lit_on      = 1'b0;
    lit_perf_on = 1'b0;
    hold        = 1'b0;
    flush       = 1'b0;
    wb_valid    = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    lit_on      = 1'b0;
    lit_perf_on = 1'b0;
    lit_name    = "";
    lit_stall   = 1'b0;
    lit_issue   = 1'b0;
    lit_byp     = 1'b0;
    lit_stg     = 2'd0;
    lit_perf    = 32'd0;
    rst         = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    drive_dec(5'd5, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 4'd1);
    expect_lit("reset_state", 1'b0, 1'b1, 1'b0, 2'd0); expect_perf(32'd0);
    step();

    // ALU x5, L=1: bypass from exe, then mem, then wb, then register file
    drive_dec(5'd1, 1'b1, 5'd2, 1'b0, 5'd5, 1'b1, 4'd1);
    expect_lit("alu_issue", 1'b0, 1'b1, 1'b0, 2'd0);
    step();
    drive_dec(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 4'd1);
    expect_lit("alu_stage0", 1'b0, 1'b1, 1'b1, 2'd0);
    step();
    expect_lit("alu_stage1", 1'b0, 1'b1, 1'b1, 2'd1);
    step();
    wb_valid = 1'b1; wb_dst = 5'd5;
    expect_lit("alu_stage2", 1'b0, 1'b1, 1'b1, 2'd2);
    step();
    expect_lit("alu_after_wb", 1'b0, 1'b1, 1'b0, 2'd0);
    step();

    // Load x6, L=2: one stall cycle
    drive_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 4'd2);
    step();
    drive_dec(5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 4'd1);
    expect_lit("load_stall", 1'b1, 1'b0, 1'b0, 2'd0); expect_perf(32'd0);
    step();
    expect_lit("load_bypass", 1'b0, 1'b1, 1'b1, 2'd0); expect_perf(32'd1);
    step();

    // MUL x7, L=4: three stall cycles
    drive_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 4'd4);
    step();
    drive_dec(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 4'd1);
    for (int i = 0; i < 3; i++) begin
      expect_lit("mul_stall", 1'b1, 1'b0, 1'b0, 2'd0);
      step();
    end
    expect_lit("mul_bypass", 1'b0, 1'b1, 1'b1, 2'd0); expect_perf(32'd4);
    step();

    // MUL x11, L=4 with two hold cycles mid-stall: five stall cycles, three counted
    drive_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 4'd4);
    step();
    drive_dec(5'd11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 4'd1);
    expect_lit("hold_stall_a", 1'b1, 1'b0, 1'b0, 2'd0);
    step();
    for (int i = 0; i < 2; i++) begin
      hold = 1'b1;
      expect_lit("hold_stall_h", 1'b1, 1'b0, 1'b0, 2'd0);
      step();
    end
    expect_lit("hold_stall_b", 1'b1, 1'b0, 1'b0, 2'd0); expect_perf(32'd5);
    step();
    expect_lit("hold_stall_c", 1'b1, 1'b0, 1'b0, 2'd0);
    step();
    expect_lit("hold_bypass", 1'b0, 1'b1, 1'b1, 2'd0); expect_perf(32'd7);
    step();

    // WAW: MUL x8 L=4 then ALU x8 L=1
    drive_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 4'd4);
    step();
    drive_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 4'd1);
    for (int i = 0; i < 3; i++) begin
      expect_lit("waw_stall", 1'b1, 1'b0, 1'b0, 2'd0);
      step();
    end
    expect_lit("waw_issue", 1'b0, 1'b1, 1'b0, 2'd0); expect_perf(32'd10);
    step();

    // x0 destination never becomes busy
    drive_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 4'd8);
    expect_lit("x0_issue", 1'b0, 1'b1, 1'b0, 2'd0);
    step();
    drive_dec(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 4'd1);
    expect_lit("x0_not_busy", 1'b0, 1'b1, 1'b0, 2'd0);
    step();

    // Flush rollback: load x9 at t0, ALU x9 at t2, flush at t3
    drive_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 4'd2);
    step();
    drive_idle();
    step();
    drive_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 4'd1);
    expect_lit("flush_alu_issue", 1'b0, 1'b1, 1'b0, 2'd0);
    step();
    drive_dec(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 4'd1);
    flush = 1'b1;
    expect_lit("flush_kill", 1'b0, 1'b0, 1'b1, 2'd0);
    step();
    drive_dec(5'd9, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 4'd1);
    expect_lit("flush_restore", 1'b0, 1'b1, 1'b1, 2'd0);
    step();
    expect_lit("flush_aged", 1'b0, 1'b1, 1'b1, 2'd1);
    step();

    // Asynchronous reset during a MUL countdown
    drive_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 4'd4);
    step();
    drive_dec(5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 4'd1);
    expect_lit("pre_rst_stall", 1'b1, 1'b0, 1'b0, 2'd0);
    step();
    #2;
    rst = 1'b1;
    expect_lit("rst_stall_drop", 1'b0, 1'b1, 1'b0, 2'd0); expect_perf(32'd0);
    step();
    rst = 1'b0;
    drive_dec(5'd12, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 4'd1);
    expect_lit("post_rst", 1'b0, 1'b1, 1'b0, 2'd0); expect_perf(32'd0);
    step();

    drive_idle();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
